// File: rtl/joy_player_mux.sv
// rtl/joy_player_mux.sv - USB/DB joystick merge with slot remap, DB debounce, coin shaping and OSD combo detect
module joy_player_mux #(
    parameter int PLAYERS     = 2,
    parameter int JOY_W       = 16,
    parameter int COIN_BIT    = 7,
    parameter int DEB_MS      = 5,
    parameter int COIN_MIN_MS = 40,
    parameter int COIN_MAX_MS = 250,
    parameter int OSD_A       = 10,
    parameter int OSD_B       = 6,
    parameter int OSD_HOLD_MS = 500
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       ce_ms,
    input  logic [2:0]                 db_players,
    input  logic [PLAYERS*JOY_W-1:0]   usb_joy,
    input  logic [PLAYERS*JOY_W-1:0]   db_joy,
    output logic [PLAYERS*JOY_W-1:0]   joy_out,
    output logic [JOY_W-1:0]           joy_any,
    output logic                       osd_req,
    output logic                       osd_level
);

    localparam int NB = PLAYERS * JOY_W;
    localparam int DW = $clog2(DEB_MS + 1);
    localparam int CW = $clog2(COIN_MAX_MS + 1);
    localparam int OW = $clog2(OSD_HOLD_MS + 1);

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD, C_JAM} coin_t;

    logic [2:0]         k_d, k_q;
    logic               remap;
    logic [NB-1:0]      stable_d, stable_q;
    logic [DW-1:0]      deb_cnt_d [NB];
    logic [DW-1:0]      deb_cnt_q [NB];
    logic [NB-1:0]      mapped;
    logic [PLAYERS-1:0] coin_in;
    logic [PLAYERS-1:0] coin_prev_d, coin_prev_q;
    coin_t              coin_st_d [PLAYERS];
    coin_t              coin_st_q [PLAYERS];
    logic [CW-1:0]      coin_cnt_d [PLAYERS];
    logic [CW-1:0]      coin_cnt_q [PLAYERS];
    logic [NB-1:0]      joy_out_d, joy_out_q;
    logic [JOY_W-1:0]   joy_any_d, joy_any_q;
    logic [OW-1:0]      osd_cnt_d, osd_cnt_q;
    logic               osd_req_d, osd_req_q;

    always_comb begin
        k_d   = (db_players > 3'(PLAYERS)) ? 3'(PLAYERS) : db_players;
        remap = (k_d != k_q);
    end

    // A bit's counter only runs while raw disagrees with the stable value.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (ce_ms) begin
                if (db_joy[i] == stable_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == DW'(DEB_MS - 1)) begin
                    stable_d[i]  = db_joy[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mapped = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (p < int'(k_d)) begin
                mapped[p*JOY_W +: JOY_W] = stable_q[p*JOY_W +: JOY_W];
            end else begin
                for (int s = 0; s < PLAYERS; s++) begin
                    if (s + int'(k_d) == p) begin
                        mapped[p*JOY_W +: JOY_W] = usb_joy[s*JOY_W +: JOY_W];
                    end
                end
            end
        end
    end

    always_comb begin
        coin_in     = '0;
        coin_prev_d = coin_prev_q;
        joy_out_d   = mapped;
        for (int p = 0; p < PLAYERS; p++) begin
            coin_in[p]     = mapped[p*JOY_W + COIN_BIT];
            coin_prev_d[p] = coin_in[p];
            coin_st_d[p]   = coin_st_q[p];
            coin_cnt_d[p]  = coin_cnt_q[p];
            if (remap) begin
                coin_st_d[p]  = C_IDLE;
                coin_cnt_d[p] = '0;
            end else begin
                case (coin_st_q[p])
                    C_IDLE: begin
                        if (coin_in[p] && !coin_prev_q[p]) begin
                            coin_st_d[p]  = C_PULSE;
                            coin_cnt_d[p] = '0;
                        end
                    end
                    C_PULSE: begin
                        if (ce_ms) begin
                            coin_cnt_d[p] = coin_cnt_q[p] + 1'b1;
                            if (coin_cnt_q[p] == CW'(COIN_MIN_MS - 1)) begin
                                coin_st_d[p] = coin_in[p] ? C_HOLD : C_IDLE;
                            end
                        end
                    end
                    C_HOLD: begin
                        if (!coin_in[p]) begin
                            coin_st_d[p]  = C_IDLE;
                            coin_cnt_d[p] = '0;
                        end else if (ce_ms) begin
                            coin_cnt_d[p] = coin_cnt_q[p] + 1'b1;
                            if (coin_cnt_q[p] == CW'(COIN_MAX_MS - 1)) begin
                                coin_st_d[p] = C_JAM;
                            end
                        end
                    end
                    default: begin
                        if (!coin_in[p]) begin
                            coin_st_d[p]  = C_IDLE;
                            coin_cnt_d[p] = '0;
                        end
                    end
                endcase
            end
            // Coin output follows the next state so it shares the register latency of the other bits.
            joy_out_d[p*JOY_W + COIN_BIT] = (coin_st_d[p] == C_PULSE) || (coin_st_d[p] == C_HOLD);
        end
    end

    always_comb begin
        joy_any_d = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            joy_any_d = joy_any_d | joy_out_d[p*JOY_W +: JOY_W];
        end
    end

    always_comb begin
        osd_level = (k_q != 3'd0) && stable_q[OSD_A] && stable_q[OSD_B];
        osd_cnt_d = osd_cnt_q;
        osd_req_d = 1'b0;
        if (!osd_level) begin
            osd_cnt_d = '0;
        end else if (ce_ms && (osd_cnt_q != OW'(OSD_HOLD_MS))) begin
            osd_cnt_d = osd_cnt_q + 1'b1;
            osd_req_d = (osd_cnt_q == OW'(OSD_HOLD_MS - 1));
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            k_q         <= '0;
            stable_q    <= '0;
            coin_prev_q <= '0;
            joy_out_q   <= '0;
            joy_any_q   <= '0;
            osd_cnt_q   <= '0;
            osd_req_q   <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
            for (int p = 0; p < PLAYERS; p++) begin
                coin_st_q[p]  <= C_IDLE;
                coin_cnt_q[p] <= '0;
            end
        end else begin
            k_q         <= k_d;
            stable_q    <= stable_d;
            coin_prev_q <= coin_prev_d;
            joy_out_q   <= joy_out_d;
            joy_any_q   <= joy_any_d;
            osd_cnt_q   <= osd_cnt_d;
            osd_req_q   <= osd_req_d;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            for (int p = 0; p < PLAYERS; p++) begin
                coin_st_q[p]  <= coin_st_d[p];
                coin_cnt_q[p] <= coin_cnt_d[p];
            end
        end
    end

    assign joy_out = joy_out_q;
    assign joy_any = joy_any_q;
    assign osd_req = osd_req_q;

endmodule

// File: tb/tb_joy_player_mux.sv
// tb/tb_joy_player_mux.sv - self-checking bench for joy_player_mux against a behavioural model
module tb_joy_player_mux;

    localparam int P    = 2;
    localparam int W    = 16;
    localparam int NB   = P * W;
    localparam int CB   = 7;
    localparam int DEB  = 5;
    localparam int CMIN = 40;
    localparam int CMAX = 250;
    localparam int OA   = 10;
    localparam int OB   = 6;
    localparam int HOLD = 500;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce_ms = 1'b0;
    logic [2:0]    db_players = 3'd0;
    logic [NB-1:0] usb_joy = '0;
    logic [NB-1:0] db_joy = '0;
    logic [NB-1:0] joy_out;
    logic [W-1:0]  joy_any;
    logic          osd_req;
    logic          osd_level;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    int req_seen = 0;

    logic [NB-1:0] m_stable;
    int            m_streak [NB];
    bit            m_act [P];
    bit            m_jam [P];
    bit            m_prev [P];
    int            m_age [P];
    int            m_k;
    int            m_osd;
    logic [NB-1:0] e_out;
    logic [W-1:0]  e_any;
    bit            e_req;
    bit            e_lvl;

    joy_player_mux dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_ms      (ce_ms),
        .db_players (db_players),
        .usb_joy    (usb_joy),
        .db_joy     (db_joy),
        .joy_out    (joy_out),
        .joy_any    (joy_any),
        .osd_req    (osd_req),
        .osd_level  (osd_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances one clock using the inputs presented at this edge.
    task automatic model_step();
        int k;
        logic [NB-1:0] src;
        bit c;
        bit lvl;
        e_req = 0;
        if (!reset_n) begin
            m_stable = '0;
            for (int i = 0; i < NB; i++) m_streak[i] = 0;
            for (int p = 0; p < P; p++) begin
                m_act[p] = 0; m_jam[p] = 0; m_prev[p] = 0; m_age[p] = 0;
            end
            m_k = 0; m_osd = 0; e_out = '0; e_any = '0; e_lvl = 0;
            return;
        end
        k = (int'(db_players) > P) ? P : int'(db_players);
        for (int p = 0; p < P; p++) begin
            if (p < k) src[p*W +: W] = m_stable[p*W +: W];
            else       src[p*W +: W] = usb_joy[(p-k)*W +: W];
        end
        e_out = src;
        for (int p = 0; p < P; p++) begin
            c = src[p*W + CB];
            if (k != m_k) begin
                m_act[p] = 0; m_jam[p] = 0; m_age[p] = 0;
            end else if (m_jam[p]) begin
                if (!c) m_jam[p] = 0;
            end else if (!m_act[p]) begin
                if (c && !m_prev[p]) begin
                    m_act[p] = 1; m_age[p] = 0;
                end
            end else begin
                if (ce_ms) m_age[p]++;
                if (m_age[p] >= CMIN && !c) m_act[p] = 0;
                else if (m_age[p] >= CMAX) begin
                    m_act[p] = 0; m_jam[p] = 1;
                end
            end
            m_prev[p] = c;
            e_out[p*W + CB] = m_act[p];
        end
        e_any = '0;
        for (int p = 0; p < P; p++) e_any = e_any | e_out[p*W +: W];
        lvl = (m_k != 0) && m_stable[OA] && m_stable[OB];
        if (!lvl) m_osd = 0;
        else if (ce_ms && m_osd < HOLD) begin
            m_osd++;
            e_req = (m_osd == HOLD);
        end
        for (int i = 0; i < NB; i++) begin
            if (ce_ms) begin
                if (db_joy[i] != m_stable[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DEB) begin
                        m_stable[i] = db_joy[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
        end
        m_k = k;
        e_lvl = (m_k != 0) && m_stable[OA] && m_stable[OB];
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("joy_out", joy_out, e_out);
            check("joy_any", 32'(joy_any), 32'(e_any));
            check("osd_req", 32'(osd_req), 32'(e_req));
            check("osd_level", 32'(osd_level), 32'(e_lvl));
            if (osd_req === 1'b1) req_seen++;
        end
    end

    task automatic cyc();
        @(posedge clk_sys);
        model_step();
        chk_en = 1;
        #1;
    endtask

    task automatic ms(input int n);
        repeat (n) begin
            ce_ms = 1; cyc();
            ce_ms = 0; cyc(); cyc(); cyc();
        end
    endtask

    task automatic ms_count(input int n, input int slot, output int hi);
        hi = 0;
        repeat (n) begin
            if (joy_out[slot*W + CB]) hi++;
            ce_ms = 1; cyc();
            ce_ms = 0; cyc(); cyc(); cyc();
        end
    endtask

    initial begin
        int hi;
        int r0;

        reset_n = 0;
        repeat (3) cyc();
        check("reset_joy_out", joy_out, 32'h0);
        check("reset_osd_level", 32'(osd_level), 32'h0);

        reset_n = 1;
        db_players = 3'd1;
        usb_joy[15:0] = 16'h0011;
        db_joy[15:0] = 16'h0004;
        db_joy[31:16] = 16'h0200;
        ms(6);
        check("map_slot0_db", 32'(joy_out[15:0]), 32'h0004);
        check("map_slot1_usb", 32'(joy_out[31:16]), 32'h0011);

        db_joy[0] = 1'b1; ms(3);
        db_joy[0] = 1'b0; ms(3);
        check("deb_glitch", 32'(joy_out[0]), 32'h0);
        db_joy[0] = 1'b1; ms(4);
        ce_ms = 1; cyc(); ce_ms = 0;
        check("deb_tick5_edge", 32'(joy_out[0]), 32'h0);
        cyc();
        check("deb_tick5_plus1", 32'(joy_out[0]), 32'h1);

        usb_joy[CB] = 1'b1; cyc(); cyc();
        usb_joy[CB] = 1'b0;
        ms_count(60, 1, hi);
        check("coin_short_ticks", 32'(hi), 32'd40);

        usb_joy[CB] = 1'b1; cyc();
        ms_count(400, 1, hi);
        check("coin_jam_ticks", 32'(hi), 32'd250);
        check("coin_jam_low", 32'(joy_out[W + CB]), 32'h0);
        usb_joy[CB] = 1'b0; cyc(); cyc();
        usb_joy[CB] = 1'b1; cyc();
        usb_joy[CB] = 1'b0;
        ms_count(60, 1, hi);
        check("coin_after_jam", 32'(hi), 32'd40);

        r0 = req_seen;
        db_joy[OA] = 1'b1; db_joy[OB] = 1'b1;
        ms(600);
        check("osd_level_held", 32'(osd_level), 32'h1);
        check("osd_one_pulse", 32'(req_seen - r0), 32'd1);
        db_joy[OA] = 1'b0; ms(10);
        check("osd_level_rel", 32'(osd_level), 32'h0);
        db_joy[OA] = 1'b1; ms(600);
        check("osd_second_pulse", 32'(req_seen - r0), 32'd2);

        db_joy[OA] = 1'b0; db_joy[OB] = 1'b0; ms(10);
        db_players = 3'd0;
        usb_joy[31:16] = 16'h0300;
        cyc(); cyc();
        usb_joy[CB] = 1'b1; cyc();
        usb_joy[CB] = 1'b0; ms(3);
        check("remap_pre_coin", 32'(joy_out[CB]), 32'h1);
        check("remap_pre_slot1", 32'(joy_out[31:16]), 32'h0300);
        db_players = 3'd2; cyc();
        check("remap_coin_off", 32'(joy_out[CB]), 32'h0);
        check("remap_slot0_db", 32'(joy_out[15:0]), 32'h0005);
        check("remap_slot1_db", 32'(joy_out[31:16]), 32'h0200);
        db_players = 3'd7; cyc(); cyc();
        check("clamp_slot1_db", 32'(joy_out[31:16]), 32'h0200);
        check("clamp_any", 32'(joy_any), 32'h0205);

        @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joy_player_mux.md
Name: joy_player_mux

Overview:
- Parametrised successor to the per-core USB/DB9/DB15 joystick merge logic; shared by every arcade core in the codebase.
- Merges USB and user-port (DB) joystick words for PLAYERS players and applies a configurable player-slot remap.
- Debounces DB inputs, shapes coin pulses with minimum and maximum widths, and detects a held OSD combo.
- Sits between hps_io / joy_db9md / joy_db15 and the core's in0/in1 builder, in the clk_sys domain.

Parameters:
- PLAYERS, 2, number of player slots (1..4).
- JOY_W, 16, bits per joystick word.
- COIN_BIT, 7, bit index of coin in the output word.
- DEB_MS, 5, DB debounce stable time in ms ticks (1..15).
- COIN_MIN_MS, 40, minimum coin pulse width in ms.
- COIN_MAX_MS, 250, maximum coin assertion in ms before forced release.
- OSD_A, 10, first DB bit of the OSD combo.
- OSD_B, 6, second DB bit of the OSD combo.
- OSD_HOLD_MS, 500, combo hold time in ms before OSD request.

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- ce_ms, in, 1, one-cycle 1 kHz tick strobe.
- db_players, in, 3, number of slots fed from DB (0..PLAYERS); values above PLAYERS are clamped to PLAYERS.
- usb_joy, in, PLAYERS*JOY_W, USB words; player p at [p*JOY_W +: JOY_W].
- db_joy, in, PLAYERS*JOY_W, raw DB words, same packing.
- joy_out, out, PLAYERS*JOY_W, merged, debounced, coin-shaped words.
- joy_any, out, JOY_W, OR of all joy_out words.
- osd_req, out, 1, one-cycle pulse when the OSD combo has been held long enough.
- osd_level, out, 1, combo currently held (debounced).

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): all debounce counters, coin FSMs and OSD counter are cleared; joy_out=0, joy_any=0, osd_req=0, osd_level=0. Reset applies regardless of ce_ms and aborts any coin pulse in progress.
- Slot mapping, registered (1-cycle latency), with k = clamped db_players:
  - Slot p<k takes debounced db[p].
  - Slot p>=k takes usb[p-k].
  - k=0 is pure USB.
  - A change of db_players takes effect on the next cycle and resets all coin FSMs to IDLE.
- Debounce, per DB bit:
  - The stable value is updated only after the raw bit differs from it for DEB_MS consecutive ce_ms ticks.
  - Any tick on which raw equals stable clears that bit's counter.
  - USB bits are not debounced.
- Coin FSM, per slot, evaluated on COIN_BIT of the mapped word; all timing advances on ce_ms only.
  - IDLE: rising edge of coin input -> PULSE; cnt=0; out coin=1.
  - PULSE: out=1; cnt++ per tick. When cnt reaches COIN_MIN_MS:
    - input released -> IDLE;
    - input still held -> HOLD.
  - HOLD: out=1; cnt++ per tick.
    - Input release -> IDLE, out=0.
    - cnt reaches COIN_MAX_MS -> JAM.
  - JAM: out=0 until the input is observed low, then IDLE. This prevents a stuck coin switch from blocking the game.
  - A release during PULSE does not shorten the pulse.
  - Rising-edge detection uses the previous clk_sys sample, so an edge between ticks is not lost.
- Non-coin bits pass through combinationally from the mapped source into the output register.
- OSD:
  - osd_level = debounced db[0][OSD_A] & db[0][OSD_B] when k>=1, else 0.
  - The hold counter increments on ce_ms while osd_level=1 and saturates at OSD_HOLD_MS.
  - osd_req pulses for exactly one clk_sys cycle at the tick where the counter reaches OSD_HOLD_MS.
  - A new osd_req requires osd_level to fall; falling clears the counter.
- joy_any is registered alongside joy_out (same latency).
- Counter widths are sized by $clog2(max+1); no wrap is permitted (all counters saturate).

Test Plan:
- Reset and map: with reset_n low 3 cycles, then PLAYERS=2, db_players=1, usb[0]=16'h0011, DB raw stable 16'h0004 for 6 ticks -> joy_out[0]=16'h0004 and joy_out[1]=16'h0011; all outputs were 0 during reset.
- Debounce: toggle DB bit0 for 3 ticks then revert (DEB_MS=5) -> joy_out bit0 never changes. Hold the toggle for 5 ticks -> bit0 changes on the 5th tick +1 cycle.
- Coin short press: USB coin high for 2 clk_sys cycles -> coin out high for exactly 40 ticks, then 0; FSM back in IDLE.
- Coin jam: coin held 400 ticks -> out high for ticks 0..249, low from tick 250 while still held. Release then press again -> new 40-tick pulse.
- OSD: db_players=1, DB bits 10 and 6 held 600 ticks -> osd_level=1 after debounce; a single osd_req pulse at hold tick 500; no second pulse. Release and re-hold -> second pulse.
- Remap mid-coin: change db_players 0->2 during PULSE -> coin out 0 next cycle; joy_out sources switch to DB.
